// File: rtl/codec_i2c_arb.sv
// Round-robin arbiter that serialises codec register writes onto one bit-level
// I2C write engine, with NACK re-sends and an en-tick watchdog per launch.
module codec_i2c_arb #(
  parameter int         NREQ       = 3,
  parameter int         MAX_RETRY  = 3,
  parameter logic [7:0] SLAVE_ADDR = 8'h34,
  parameter int         WDOG_TICKS = 48
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [NREQ-1:0]     req,
  input  logic [16*NREQ-1:0]  req_data,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     req_done,
  output logic [NREQ-1:0]     req_err,
  output logic                busy,
  output logic                i2c_go,
  output logic [23:0]         i2c_data,
  input  logic                i2c_done,
  input  logic                i2c_ack
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [5:0]    WDOG_LAST   = 6'(WDOG_TICKS - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, CHECK, GAP} state_t;

  state_t          state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   winner_q;
  logic [RW-1:0]   retry_q;
  logic [5:0]      wdog_q;
  logic            retry_mark_q;
  logic [15:0]     word_q;
  logic            go_q;
  logic            busy_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [NREQ-1:0] err_q;

  logic [15:0]     slice   [NREQ];
  logic [IW-1:0]   cand    [NREQ];
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

  // cand[k] is the requester k+1 places after the last winner.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign slice[gi]   = req_data[16*gi +: 16];
      assign cand[gi]    = IW'((int'(last_q) + gi + 1) % NREQ);
      assign pick_oh[gi] = pick_vld && (pick_idx == IW'(gi));
      assign win_oh[gi]  = (winner_q == IW'(gi));
    end
  endgenerate

  // Scan from the farthest candidate inward so the nearest active one wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= IW'(NREQ - 1);
      winner_q     <= '0;
      retry_q      <= '0;
      wdog_q       <= '0;
      retry_mark_q <= 1'b0;
      word_q       <= '0;
      go_q         <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      // busy stays up through the completion pulse and drops right after it.
      if ((|done_q) || (|err_q)) busy_q <= 1'b0;
      if (en) begin
        case (state_q)
          IDLE: begin
            if (pick_vld) begin
              winner_q <= pick_idx;
              last_q   <= pick_idx;
              word_q   <= slice[pick_idx];
              grant_q  <= pick_oh;
              busy_q   <= 1'b1;
              retry_q  <= '0;
              wdog_q   <= '0;
              go_q     <= 1'b1;
              state_q  <= LAUNCH;
            end
          end
          LAUNCH, RUN: begin
            if (state_q == RUN && i2c_done) begin
              state_q <= CHECK;
            end else if (wdog_q == WDOG_LAST) begin
              err_q        <= win_oh;
              go_q         <= 1'b0;
              retry_mark_q <= 1'b0;
              state_q      <= GAP;
            end else begin
              if (wdog_q != 6'h3f) wdog_q <= wdog_q + 6'd1;
              if (state_q == LAUNCH && !i2c_done) state_q <= RUN;
            end
          end
          CHECK: begin
            go_q    <= 1'b0;
            state_q <= GAP;
            if (!i2c_ack) begin
              done_q       <= win_oh;
              retry_mark_q <= 1'b0;
            end else if (retry_q < RETRY_LIMIT) begin
              retry_q      <= retry_q + 1'b1;
              retry_mark_q <= 1'b1;
            end else begin
              err_q        <= win_oh;
              retry_mark_q <= 1'b0;
            end
          end
          GAP: begin
            if (retry_mark_q) begin
              wdog_q  <= '0;
              go_q    <= 1'b1;
              state_q <= LAUNCH;
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign grant    = grant_q;
  assign req_done = done_q;
  assign req_err  = err_q;
  assign busy     = busy_q;
  assign i2c_go   = go_q;
  assign i2c_data = {SLAVE_ADDR, word_q};

endmodule

// File: tb/tb_codec_i2c_arb.sv
// Bench for codec_i2c_arb: behavioural I2C engine, round-robin/outcome model,
// directed scenarios plus randomized request bursts.
`timescale 1ns/1ps
module tb_codec_i2c_arb;
  localparam int NREQ       = 3;
  localparam int MAX_RETRY  = 3;
  localparam int WDOG_TICKS = 48;
  localparam int EN_DIV     = 4;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              en       = 1'b0;
  logic [NREQ-1:0]   req      = '0;
  logic [16*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   grant, req_done, req_err;
  logic              busy, i2c_go;
  logic [23:0]       i2c_data;
  logic              i2c_done = 1'b1;
  logic              i2c_ack  = 1'b0;

  codec_i2c_arb #(.NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .SLAVE_ADDR(8'h34),
                  .WDOG_TICKS(WDOG_TICKS)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .req_data(req_data),
    .grant(grant), .req_done(req_done), .req_err(req_err), .busy(busy),
    .i2c_go(i2c_go), .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_ack(i2c_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    int          idx;
    int          gos;
    int          grant_tick;
    int          tick;
    bit          data_ok;
    logic [23:0] first_data;
  } ev_t;

  int errors = 0;
  int checks = 0;
  ev_t ev_q[$];
  int  got_order[$];
  logic [23:0] last_first_data = '0;

  int          tick = 0, div = 0;
  logic [15:0] tb_word [NREQ];
  int          nack_plan [NREQ];
  bit          stuck = 1'b0;
  int          cur_win = 0, cur_grant_tick = 0, go_cnt = 0, attempt = 0;
  bit          data_ok = 1'b1, go_prev = 1'b0;
  logic [23:0] first_data = '0;
  int          eng_phase = 0, eng_cnt = 0, eng_len = 0;
  int          onehot_bad = 0, busy_bad = 0;
  int          model_last = NREQ - 1;

  // Monitor, engine model and en divider, all evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (en) tick++;
      if (!reset) begin
        if ($countones(grant | req_done | req_err) > 1) onehot_bad++;
        if ((|(grant | req_done | req_err)) && !busy) busy_bad++;
        for (int i = 0; i < NREQ; i++) begin
          if (grant[i]) begin
            cur_win = i; cur_grant_tick = tick; go_cnt = 0; attempt = 0; data_ok = 1'b1;
            req[i] = 1'b0;
            req_data[16*i +: 16] = 16'($urandom);
          end
        end
        if (i2c_go) begin
          if (!go_prev) begin
            go_cnt++;
            if (go_cnt == 1) first_data = i2c_data;
          end
          if (i2c_data !== {8'h34, tb_word[cur_win]}) data_ok = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (req_done[i] || req_err[i])
            ev_q.push_back('{bit'(req_err[i]), i, go_cnt, cur_grant_tick, tick, data_ok, first_data});
        end
      end
      go_prev = i2c_go;
      if (!i2c_go) begin
        eng_phase = 0;
        i2c_done  = 1'b1;
      end else if (en) begin
        if (eng_phase == 0) begin
          if (!stuck) begin
            eng_phase = 1; eng_cnt = 0; eng_len = $urandom_range(2, 6); i2c_done = 1'b0;
          end
        end else if (eng_phase == 1) begin
          eng_cnt++;
          if (eng_cnt >= eng_len) begin
            i2c_done = 1'b1;
            i2c_ack  = (attempt < nack_plan[cur_win]);
            attempt++;
            eng_phase = 2;
          end
        end
      end
      en  = (div == EN_DIV - 1);
      div = (div + 1) % EN_DIV;
    end
  end

  function automatic int rr_pick(logic [NREQ-1:0] m, int last);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    model_last = NREQ - 1;
    ev_q.delete();
    stuck = 1'b0;
  endtask

  // Raise the masked requests and compare every completion with the model.
  task automatic run_batch(input logic [NREQ-1:0] mask, input string name);
    logic [NREQ-1:0] pend;
    int exp_idx[$];
    int last, n, budget, w, exp_gos, prev_tick;
    bit exp_err;
    ev_t ev;
    for (int i = 0; i < NREQ; i++)
      if (mask[i]) req_data[16*i +: 16] = tb_word[i];
    req = req | mask;
    pend = mask; last = model_last;
    while (pend != '0) begin
      w = rr_pick(pend, last);
      exp_idx.push_back(w);
      pend[w] = 1'b0;
      last = w;
    end
    model_last = last;
    n = $countones(mask);
    budget = 0;
    while (ev_q.size() < n && budget < 6000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (ev_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d completions want %0d", name, ev_q.size(), n);
    end
    got_order.delete();
    prev_tick = 0;
    for (int j = 0; j < n && ev_q.size() > 0; j++) begin
      ev = ev_q.pop_front();
      w  = exp_idx[j];
      got_order.push_back(ev.idx);
      last_first_data = ev.first_data;
      exp_err = stuck || (nack_plan[w] > MAX_RETRY);
      exp_gos = stuck ? 1 : (((nack_plan[w] < MAX_RETRY) ? nack_plan[w] : MAX_RETRY) + 1);
      checks++;
      if (ev.idx !== w) begin
        errors++; $display("FAIL %s winner#%0d: got %0d want %0d", name, j, ev.idx, w);
      end
      checks++;
      if (ev.is_err !== exp_err) begin
        errors++; $display("FAIL %s err_flag#%0d: got %0d want %0d", name, j, ev.is_err, exp_err);
      end
      checks++;
      if (ev.gos !== exp_gos) begin
        errors++; $display("FAIL %s go_pulses#%0d: got %0d want %0d", name, j, ev.gos, exp_gos);
      end
      checks++;
      if (ev.data_ok !== 1'b1) begin
        errors++; $display("FAIL %s i2c_data#%0d: got mismatch want %h", name, j, {8'h34, tb_word[w]});
      end
      if (stuck) begin
        checks++;
        if (ev.tick - ev.grant_tick !== WDOG_TICKS) begin
          errors++;
          $display("FAIL %s wdog_ticks: got %0d want %0d", name, ev.tick - ev.grant_tick, WDOG_TICKS);
        end
      end
      if (j > 0) begin
        checks++;
        if (ev.grant_tick - prev_tick !== 2) begin
          errors++; $display("FAIL %s gap#%0d: got %0d ticks want 2", name, j, ev.grant_tick - prev_tick);
        end
      end
      prev_tick = ev.tick;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || i2c_go !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: got busy=%b go=%b want 0/0", name, busy, i2c_go);
    end
    $display("batch %s mask=%b done", name, mask);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (grant !== '0 || req_done !== '0 || req_err !== '0) begin
      errors++; $display("FAIL reset_pulses: got %b/%b/%b want 0", grant, req_done, req_err);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (i2c_go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b want 0", i2c_go); end
    checks++;
    if (i2c_data !== 24'h340000) begin
      errors++; $display("FAIL reset_data: got %h want 340000", i2c_data);
    end
    apply_reset();
    repeat (12) @(negedge clk);
    checks++;
    if (i2c_go !== 1'b0 || busy !== 1'b0 || grant !== '0) begin
      errors++; $display("FAIL idle_no_req: got go=%b busy=%b grant=%b want 0", i2c_go, busy, grant);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    tb_word[0] = 16'h1201; nack_plan[0] = 0;
    run_batch(3'b001, "single");
    checks++;
    if (last_first_data !== 24'h341201) begin
      errors++; $display("FAIL single_data: got %h want 341201", last_first_data);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NREQ; i++) begin tb_word[i] = 16'($urandom); nack_plan[i] = 0; end
      run_batch(3'b111, "burst");
      checks++;
      if (got_order.size() != 3 || got_order[0] != 0 || got_order[1] != 1 || got_order[2] != 2) begin
        errors++; $display("FAIL burst_order#%0d: got %p want 0,1,2", b, got_order);
      end
    end
  endtask

  task automatic test_retry();
    tb_word[2] = 16'($urandom); nack_plan[2] = 2;
    run_batch(3'b100, "retry");
  endtask

  task automatic test_exhaust();
    tb_word[0] = 16'($urandom); nack_plan[0] = 9;
    run_batch(3'b001, "exhaust");
  endtask

  task automatic test_watchdog();
    stuck = 1'b1;
    tb_word[1] = 16'($urandom); nack_plan[1] = 0;
    run_batch(3'b010, "watchdog");
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    tb_word[1] = 16'($urandom); nack_plan[1] = 0;
    req_data[31:16] = tb_word[1];
    req[1] = 1'b1;
    while (!(eng_phase == 1 && i2c_go === 1'b1) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (budget >= 2000) begin errors++; $display("FAIL reset_mid_start: got no RUN want RUN"); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (i2c_go !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: got go=%b busy=%b want 0/0", i2c_go, busy);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (ev_q.size() != 0 || req_done !== '0 || req_err !== '0) begin
      errors++; $display("FAIL reset_mid_pulses: got %0d events want 0", ev_q.size());
    end
    reset = 1'b0;
    model_last = NREQ - 1;
    req = '0;
    tb_word[1] = 16'($urandom);
    run_batch(3'b010, "after_reset");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] mask;
    for (int r = 0; r < 6; r++) begin
      mask = NREQ'($urandom_range(1, 7));
      for (int i = 0; i < NREQ; i++) begin
        tb_word[i]   = 16'($urandom);
        nack_plan[i] = $urandom_range(0, 4);
      end
      run_batch(mask, "random");
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (onehot_bad != 0) begin errors++; $display("FAIL onehot: got %0d bad cycles want 0", onehot_bad); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL busy_cover: got %0d bad cycles want 0", busy_bad); end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin tb_word[i] = '0; nack_plan[i] = 0; end
    test_reset();
    test_single();
    test_back_to_back();
    test_retry();
    test_exhaust();
    test_watchdog();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/codec_i2c_arb.md
CODEC_I2C_ARB -- requirements
Module: codec_i2c_arb

Parameters
REQ-001 NREQ, 3, number of register-write requesters; index 0 is the boot configuration sequencer.
REQ-002 MAX_RETRY, 3, number of re-sends after a NACK before a request is failed.
REQ-003 SLAVE_ADDR, 8'h34, codec I2C write address placed in i2c_data[23:16].
REQ-004 WDOG_TICKS, 48, number of en ticks allowed between launch and i2c_done rising.

Interface
REQ-005 clk  in  1  system clock, 50 MHz.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  one-clk pulse per I2C bit tick, from the clk/1024 divider; it is the only pacing input.
REQ-008 req  in  NREQ  per-requester level request; held high with stable req_data until grant.
REQ-009 req_data  in  16*NREQ  per-requester {reg_addr[15:9], reg_val[8:0]}; slice i is bits [16i+15:16i].
REQ-010 grant  out  NREQ  one-clk one-hot pulse: req_data slice captured.
REQ-011 req_done  out  NREQ  one-clk pulse: write of granted requester was ACKed.
REQ-012 req_err  out  NREQ  one-clk pulse: write failed (retries exhausted or watchdog).
REQ-013 busy  out  1  high from grant until the done/err pulse, inclusive.
REQ-014 i2c_go  out  1  run command to the bit-level I2C write engine; low holds the engine at bit 0.
REQ-015 i2c_data  out  24  {SLAVE_ADDR, captured word}, stable while i2c_go is high.
REQ-016 i2c_done  in  1  engine done flag; high when idle, low while sending, high again at stop.
REQ-017 i2c_ack  in  1  engine NACK flag, valid when i2c_done is high; 1 = at least one NACK.

Function
REQ-018 FSM states: IDLE, LAUNCH, RUN, CHECK, GAP; state changes occur only on clk edges where en=1, except grant and the done/err pulses, which are single clk cycles.
REQ-019 IDLE: if any req bit is high on an en cycle, pick the winner round-robin; search starts at last_winner+1 mod NREQ. Capture its slice, pulse grant, clear retry_cnt, go to LAUNCH.
REQ-020 Round-robin pointer resets to NREQ-1, so requester 0 wins the first arbitration.
REQ-021 LAUNCH: i2c_go=1 and watchdog cleared; go to RUN on the first en tick with i2c_done=0.
REQ-022 RUN: on the first en tick with i2c_done=1, go to CHECK.
REQ-023 CHECK: if i2c_ack=0, pulse req_done[winner] and go to GAP; if i2c_ack=1 and retry_cnt<MAX_RETRY, increment retry_cnt and go to GAP marked retry; otherwise pulse req_err[winner] and go to GAP.
REQ-024 GAP: i2c_go=0 for exactly one en tick; then go to LAUNCH if marked retry, else to IDLE.
REQ-025 i2c_go is high only in LAUNCH, RUN and CHECK.
REQ-026 Watchdog: 6-bit counter of en ticks in LAUNCH+RUN; on reaching WDOG_TICKS, pulse req_err, go to GAP without retry. The counter saturates and never wraps.
REQ-027 req_data changes after grant have no effect; i2c_data is driven only from the captured register.
REQ-028 A req bit still high after its done/err is a new request, arbitrated normally.
REQ-029 Simultaneous requests: exactly one grant per arbitration; no requester waits more than NREQ-1 transactions.
REQ-030 At most one bit of grant|req_done|req_err is high in any cycle.

Reset
REQ-031 On reset: state=IDLE, i2c_go=0, grant=req_done=req_err=0, busy=0, retry_cnt=0, watchdog=0, captured word=0, pointer=NREQ-1.
REQ-032 Reset asserted mid-transaction aborts it without a done/err pulse; i2c_go drops asynchronously.

Verification
REQ-033 Single write: req[0]=1, data 16'h1201, engine model ACKs -> grant[0], i2c_data=24'h341201 during go, one req_done[0] pulse, busy low after.
REQ-034 All three request together, all ACK -> grant order 0,1,2; a second burst grants 0,1,2 again; one GAP tick between transactions.
REQ-035 Model NACKs the first two attempts, ACKs the third -> three go pulses, same i2c_data each time, one req_done.
REQ-036 Model always NACKs -> 4 go pulses (1+MAX_RETRY), then one req_err, no req_done.
REQ-037 Model never drops i2c_done -> req_err after 48 en ticks, i2c_go low for one tick, IDLE.
REQ-038 Reset pulsed during RUN -> i2c_go low immediately, no pulses; next req[1] is granted and completes normally.
